// File: rtl/ahb2apb_bridge_mslv_pkg.sv
// Shared types and helpers for the multi-slave AHB-Lite to APB bridge.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } bridge_state_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Width of the slave index field; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahb2apb_bridge_mslv_if.sv
// AHB-Lite slave side and APB master side of the bridge, bundled as one interface.
interface ahb2apb_bridge_mslv_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  logic                      HSEL;
  logic [1:0]                HTRANS;
  logic                      HWRITE;
  logic [ADDR_W-1:0]         HADDR;
  logic [DATA_W-1:0]         HWDATA;
  logic                      HREADYIN;
  logic                      HREADYOUT;
  logic                      HRESP;
  logic [DATA_W-1:0]         HRDATA;
  logic [ADDR_W-1:0]         PADDR;
  logic [DATA_W-1:0]         PWDATA;
  logic                      PWRITE;
  logic [NUM_SLV-1:0]        PSEL;
  logic                      PENABLE;
  logic [NUM_SLV*DATA_W-1:0] PRDATA;
  logic [NUM_SLV-1:0]        PREADY;
  logic [NUM_SLV-1:0]        PSLVERR;

  // Bridge view: AHB slave, APB master.
  modport slave (
    input  HSEL, HTRANS, HWRITE, HADDR, HWDATA, HREADYIN, PRDATA, PREADY, PSLVERR,
    output HREADYOUT, HRESP, HRDATA, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

  // Environment view: drives the AHB request and the APB slave responses.
  modport master (
    output HSEL, HTRANS, HWRITE, HADDR, HWDATA, HREADYIN, PRDATA, PREADY, PSLVERR,
    input  HREADYOUT, HRESP, HRDATA, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
endinterface

// File: rtl/ahb2apb_bridge_mslv_resp_mux.sv
// Picks the addressed APB slave's response; an index with no slave behind it reads as zero.
module apb_resp_mux
  import ahb_apb_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = idx_width(NUM_SLV)
) (
  input  logic [IDX_W-1:0]          idx,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr,
  output logic [DATA_W-1:0]         prdata_sel,
  output logic                      pready_sel,
  output logic                      pslverr_sel
);

  // Index compare per slave; unmatched index leaves the zero defaults.
  always_comb begin
    prdata_sel  = '0;
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx == IDX_W'(i)) begin
        prdata_sel  = prdata[i*DATA_W +: DATA_W];
        pready_sel  = pready[i];
        pslverr_sel = pslverr[i];
      end
    end
  end

endmodule

// File: rtl/ahb2apb_bridge_mslv.sv
// AHB-Lite to multi-slave APB bridge with address decode, wait states,
// slave error mapping, optional access timeout and back-to-back issue.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no transfer in flight, ready to accept
// ST_LATCH  | AHB data phase, write data captured into PWDATA
// ST_SETUP  | APB setup phase, PSEL high, PENABLE low
// ST_ACCESS | APB access phase, waiting on PREADY of the selected slave
// ST_ERR1   | first ERROR cycle (HREADYOUT low)
// ST_ERR2   | second ERROR cycle (HREADYOUT high), may accept a new transfer
module ahb2apb_bridge_mslv
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SLV_AW  = 12,
  parameter int TIMEOUT = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  ahb2apb_bridge_mslv_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_SLV);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  bridge_state_t      state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic               write_q;
  logic [IDX_W-1:0]   idx_q, idx_in;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_SLV-1:0] psel_q;
  logic               penable_q;
  logic [DATA_W-1:0]  pwdata_q;
  logic               req, dec_err, accept, timeout_hit;
  logic               hready_d, hresp_d;
  logic [DATA_W-1:0]  hrdata_d;
  logic [DATA_W-1:0]  prdata_sel;
  logic               pready_sel, pslverr_sel;

  assign idx_in      = bus.HADDR[SLV_AW +: IDX_W];
  assign req         = bus.HSEL && (htrans_t'(bus.HTRANS) inside {NONSEQ, SEQ}) && bus.HREADYIN;
  assign dec_err     = (32'(idx_in) >= NUM_SLV) || ((bus.HADDR >> (SLV_AW + IDX_W)) != '0);
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  apb_resp_mux #(
    .NUM_SLV (NUM_SLV),
    .DATA_W  (DATA_W),
    .IDX_W   (IDX_W)
  ) u_resp_mux (
    .idx         (idx_q),
    .prdata      (bus.PRDATA),
    .pready      (bus.PREADY),
    .pslverr     (bus.PSLVERR),
    .prdata_sel  (prdata_sel),
    .pready_sel  (pready_sel),
    .pslverr_sel (pslverr_sel)
  );

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and AHB response; acceptance only happens where HREADYOUT is high.
  always_comb begin
    state_d  = state_q;
    hready_d = 1'b1;
    hresp_d  = HRESP_OKAY;
    hrdata_d = '0;
    accept   = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (state_q == ST_ERR2) hresp_d = HRESP_ERROR;
        accept  = req;
        state_d = req ? (dec_err ? ST_ERR1 : ST_LATCH) : ST_IDLE;
      end
      ST_LATCH: begin
        hready_d = 1'b0;
        state_d  = ST_SETUP;
      end
      ST_SETUP: begin
        hready_d = 1'b0;
        state_d  = ST_ACCESS;
      end
      ST_ACCESS: begin
        hready_d = 1'b0;
        if (pready_sel && !pslverr_sel) begin
          hready_d = 1'b1;
          if (!write_q) hrdata_d = prdata_sel;
          accept   = req;
          state_d  = req ? (dec_err ? ST_ERR1 : ST_LATCH) : ST_IDLE;
        end else if (pready_sel || timeout_hit) begin
          state_d = ST_ERR1;
        end
      end
      ST_ERR1: begin
        hready_d = 1'b0;
        hresp_d  = HRESP_ERROR;
        state_d  = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address-phase capture of address, direction and slave index.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      addr_q  <= bus.HADDR;
      write_q <= bus.HWRITE;
      idx_q   <= idx_in;
    end
  end

  // Write data is taken in the data phase and held until the next write.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                           pwdata_q <= '0;
    else if (state_q == ST_LATCH && write_q) pwdata_q <= bus.HWDATA;
  end

  // APB strobes follow the upcoming state so they are clean flop outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      psel_q    <= '0;
      penable_q <= 1'b0;
    end else begin
      psel_q    <= (state_d == ST_SETUP || state_d == ST_ACCESS) ? (NUM_SLV'(1) << idx_q) : '0;
      penable_q <= (state_d == ST_ACCESS);
    end
  end

  // Access-cycle counter for the timeout abort; saturates rather than wraps.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                             cnt_q <= '0;
    else if (state_d == ST_SETUP)             cnt_q <= '0;
    else if (state_q == ST_ACCESS && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.HREADYOUT = hready_d;
  assign bus.HRESP     = hresp_d;
  assign bus.HRDATA    = hrdata_d;
  assign bus.PADDR     = addr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PWRITE    = write_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;

endmodule

// File: tb/tb_ahb2apb_bridge_mslv.sv
// Directed bench for the AHB-to-APB bridge: a transfer-timeline model predicts
// every output per cycle, plus literal spot checks at key cycles.
module tb_ahb2apb_bridge_mslv;
  import ahb_apb_pkg::*;

  localparam int TMO = 8;
  localparam int N   = 1024;
  localparam logic [31:0] SD0 = 32'h0BAD_F00D;
  localparam logic [31:0] SD1 = 32'h1234_5678;
  localparam logic [31:0] SD2 = 32'h5A5A_A5A5;
  localparam logic [31:0] SD3 = 32'hC0DE_0003;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb2apb_bridge_mslv_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4)) bus ();

  ahb2apb_bridge_mslv #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SLV_AW(12), .TIMEOUT(TMO)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  // APB slave behaviour: ready after wait_cfg access cycles unless stuck.
  int acc_cnt   = 0;
  int wait_cfg  = 0;
  bit err_cfg   = 1'b0;
  bit stuck_cfg = 1'b0;
  always @(posedge HCLK) acc_cnt <= bus.PENABLE ? acc_cnt + 1 : 0;
  assign bus.PREADY   = (bus.PENABLE && !stuck_cfg && acc_cnt >= wait_cfg) ? bus.PSEL : 4'b0;
  assign bus.PSLVERR  = err_cfg ? bus.PREADY : 4'b0;
  assign bus.PRDATA   = {SD3, SD2, SD1, SD0};
  assign bus.HREADYIN = bus.HREADYOUT;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit run_chk = 1'b0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Expected per-cycle outputs.
  logic        e_hready [N];
  logic        e_hresp  [N];
  logic [3:0]  e_psel   [N];
  logic        e_pen    [N];
  logic [31:0] e_hrdata [N];
  logic        e_apb    [N];
  logic [31:0] e_paddr  [N];
  logic        e_pwr    [N];
  logic [31:0] e_pwdata [N];

  function automatic void clear_from(input int c);
    for (int i = c; i < N; i++) begin
      e_hready[i] = 1'b1; e_hresp[i] = 1'b0; e_psel[i] = 4'b0; e_pen[i] = 1'b0;
      e_hrdata[i] = '0;   e_apb[i]   = 1'b0; e_paddr[i] = '0;  e_pwr[i] = 1'b0;
      e_pwdata[i] = '0;
    end
  endfunction

  function automatic logic [31:0] slave_data(input int idx);
    case (idx)
      0:       return SD0;
      1:       return SD1;
      2:       return SD2;
      default: return SD3;
    endcase
  endfunction

  // Timeline of one transfer accepted in cycle a: data phase, one setup cycle,
  // an access phase of waits+1 cycles (or TMO when the slave never answers),
  // then either an OKAY completion or a two-cycle ERROR response.
  function automatic void plan(input int a, input logic [31:0] addr, input bit wr,
                               input logic [31:0] data, input int waits,
                               input bit slverr, input bit stuck);
    int s, len, last, idx;
    if ((addr >> 14) != 0) begin
      e_hready[a+1] = 1'b0; e_hresp[a+1] = 1'b1;
      e_hready[a+2] = 1'b1; e_hresp[a+2] = 1'b1;
      return;
    end
    idx  = int'(addr[13:12]);
    s    = a + 2;
    len  = stuck ? TMO : waits + 1;
    last = s + len;
    e_hready[a+1] = 1'b0;
    for (int c = s; c <= last; c++) begin
      e_hready[c] = 1'b0;
      e_psel[c]   = 4'(1 << idx);
      e_pen[c]    = (c > s);
      e_apb[c]    = 1'b1;
      e_paddr[c]  = addr;
      e_pwr[c]    = wr;
      e_pwdata[c] = data;
    end
    if (stuck || slverr) begin
      e_hready[last+1] = 1'b0; e_hresp[last+1] = 1'b1;
      e_hready[last+2] = 1'b1; e_hresp[last+2] = 1'b1;
    end else begin
      e_hready[last] = 1'b1;
      e_hrdata[last] = wr ? 32'h0 : slave_data(idx);
    end
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge HCLK) begin
    if (run_chk && cyc < N) begin
      cmp("HREADYOUT", 64'(bus.HREADYOUT), 64'(e_hready[cyc]));
      cmp("HRESP",     64'(bus.HRESP),     64'(e_hresp[cyc]));
      cmp("HRDATA",    64'(bus.HRDATA),    64'(e_hrdata[cyc]));
      cmp("PSEL",      64'(bus.PSEL),      64'(e_psel[cyc]));
      cmp("PENABLE",   64'(bus.PENABLE),   64'(e_pen[cyc]));
      if (e_apb[cyc]) begin
        cmp("PADDR",  64'(bus.PADDR),  64'(e_paddr[cyc]));
        cmp("PWRITE", 64'(bus.PWRITE), 64'(e_pwr[cyc]));
        if (e_pwr[cyc]) cmp("PWDATA", 64'(bus.PWDATA), 64'(e_pwdata[cyc]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  // Present one NONSEQ transfer, wait (bounded) for acceptance, then go idle.
  // Returns in the data-phase cycle; acc is the acceptance cycle.
  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] data,
                      input int waits, input bit slverr, input bit stuck, output int acc);
    bus.HSEL   = 1'b1;
    bus.HTRANS = NONSEQ;
    bus.HADDR  = addr;
    bus.HWRITE = wr;
    acc = -1;
    for (int k = 0; k < 40 && acc < 0; k++) begin
      @(negedge HCLK);
      if (bus.HREADYOUT) acc = cyc;
      @(posedge HCLK);
      #1;
    end
    bus.HSEL   = 1'b0;
    bus.HTRANS = IDLE;
    bus.HWDATA = wr ? data : 32'h0;
    if (acc < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout addr %0h: got no HREADYOUT want acceptance", addr);
    end else begin
      wait_cfg  = waits;
      err_cfg   = slverr;
      stuck_cfg = stuck;
      plan(acc, addr, wr, data, waits, slverr, stuck);
    end
  endtask

  initial begin
    int a, a2;
    bus.HSEL   = 1'b0;
    bus.HTRANS = IDLE;
    bus.HWRITE = 1'b0;
    bus.HADDR  = '0;
    bus.HWDATA = '0;
    clear_from(0);
    run_chk = 1'b1;

    repeat (3) @(posedge HCLK);
    #2;
    cmp("rst_hready", 64'(bus.HREADYOUT), 64'd1);
    cmp("rst_psel",   64'(bus.PSEL),      64'd0);
    cmp("rst_paddr",  64'(bus.PADDR),     64'd0);
    HRESETn = 1'b1;
    tick(2);

    // Selected but BUSY: no APB activity, zero-wait OKAY.
    bus.HSEL = 1'b1; bus.HTRANS = BUSY; bus.HADDR = 32'h2000;
    tick(2);
    bus.HSEL = 1'b0; bus.HTRANS = IDLE;
    #1;
    cmp("busy_psel", 64'(bus.PSEL), 64'd0);
    tick(1);

    // 1: zero-wait write to slave 2.
    xfer(32'h0000_2010, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, a);
    tick(1); #1;
    cmp("t1_psel",   64'(bus.PSEL),      64'h4);
    cmp("t1_paddr",  64'(bus.PADDR),     64'h2010);
    cmp("t1_pwdata", 64'(bus.PWDATA),    64'hDEAD_BEEF);
    cmp("t1_pwrite", 64'(bus.PWRITE),    64'd1);
    tick(1); #1;
    cmp("t1_hready", 64'(bus.HREADYOUT), 64'd1);
    cmp("t1_hresp",  64'(bus.HRESP),     64'd0);
    tick(3);

    // 2: read from slave 1 with three wait cycles.
    xfer(32'h0000_1004, 1'b0, 32'h0, 3, 1'b0, 1'b0, a);
    tick(4); #1;
    cmp("t2_hrdata_wait", 64'(bus.HRDATA),    64'd0);
    cmp("t2_hready_wait", 64'(bus.HREADYOUT), 64'd0);
    tick(1); #1;
    cmp("t2_hrdata",      64'(bus.HRDATA),    64'h1234_5678);
    tick(1); #1;
    cmp("t2_psel_after",  64'(bus.PSEL),      64'd0);
    cmp("t2_hrdata_after",64'(bus.HRDATA),    64'd0);
    tick(2);

    // 3: slave error on a write to slave 3.
    xfer(32'h0000_3008, 1'b1, 32'hCAFE_0001, 0, 1'b1, 1'b0, a);
    tick(2); #1;
    cmp("t3_psel_acc",  64'(bus.PSEL),      64'h8);
    tick(1); #1;
    cmp("t3_err1_resp", 64'(bus.HRESP),     64'd1);
    cmp("t3_err1_rdy",  64'(bus.HREADYOUT), 64'd0);
    cmp("t3_err1_psel", 64'(bus.PSEL),      64'd0);
    tick(1); #1;
    cmp("t3_err2_rdy",  64'(bus.HREADYOUT), 64'd1);
    tick(2);

    // 4: decode error, address above the last slave window.
    xfer(32'h0001_0000, 1'b0, 32'h0, 0, 1'b0, 1'b0, a);
    #1;
    cmp("t4_err1_resp", 64'(bus.HRESP),     64'd1);
    cmp("t4_psel",      64'(bus.PSEL),      64'd0);
    tick(1); #1;
    cmp("t4_err2_rdy",  64'(bus.HREADYOUT), 64'd1);
    tick(2);

    // 5: slave 0 never ready, timeout after eight access cycles.
    xfer(32'h0000_0040, 1'b0, 32'h0, 0, 1'b0, 1'b1, a);
    tick(9); #1;
    cmp("t5_psel_last", 64'(bus.PSEL),  64'h1);
    tick(1); #1;
    cmp("t5_psel_drop", 64'(bus.PSEL),  64'd0);
    cmp("t5_err_resp",  64'(bus.HRESP), 64'd1);
    tick(3);

    // 6: back-to-back write slave 0 then read slave 3.
    xfer(32'h0000_0000, 1'b1, 32'h1111_2222, 0, 1'b0, 1'b0, a);
    xfer(32'h0000_3000, 1'b0, 32'h0, 0, 1'b0, 1'b0, a2);
    #1;
    cmp("t6_gap",      64'(a2 - a),        64'd3);
    cmp("t6_psel_gap", 64'(bus.PSEL),      64'd0);
    tick(1); #1;
    cmp("t6_psel2",    64'(bus.PSEL),      64'h8);
    tick(1); #1;
    cmp("t6_hrdata",   64'(bus.HRDATA),    64'hC0DE_0003);
    tick(2);

    // Reset pulse during SETUP.
    xfer(32'h0000_2004, 1'b1, 32'h0F0F_0F0F, 0, 1'b0, 1'b0, a);
    tick(1); #1;
    cmp("rs_psel_setup", 64'(bus.PSEL), 64'h4);
    clear_from(cyc);
    HRESETn = 1'b0;
    #1;
    cmp("rs_psel",   64'(bus.PSEL),      64'd0);
    cmp("rs_pen",    64'(bus.PENABLE),   64'd0);
    cmp("rs_hready", 64'(bus.HREADYOUT), 64'd1);
    tick(1);
    HRESETn = 1'b1;
    tick(3);

    run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test want finish");
    $fatal(1);
  end

endmodule
